// File: rtl/pulse_sched_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sched_pkg
// Shared definitions for the frame-level pulse scheduler:
//   - default channel count and gap-field width
//   - overrun counter width
//   - FSM state encoding (plain 2-bit constants for legacy tooling)
// -----------------------------------------------------------------------------
package pulse_sched_pkg;

    localparam int NCH_DEF   = 32;
    localparam int GAP_W_DEF = 8;
    localparam int OVR_W     = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SCAN = 2'd1;
    localparam state_t S_GAP  = 2'd2;

endpackage

// File: rtl/pulse_sched_if.sv
// -----------------------------------------------------------------------------
// pulse_sched_if
// Bundles the scheduler's frame input, configuration and strobe/status
// outputs.
//   master : the scheduler (consumes fd/ch_en/gap, drives strobes and status)
//   slave  : the surrounding logic (drives fd/ch_en/gap, observes the rest)
// Signals:
//   fd          frame strobe level, may be asynchronous to clk
//   ch_en       per-channel enable, captured at frame start
//   gap         idle cycles after each enabled strobe, captured at frame start
//   stb         one-hot single-cycle channel strobe
//   ch_idx      channel currently evaluated, 0 when idle
//   busy        scan in progress
//   frame_done  single-cycle pulse when a scan completes
//   overrun     single-cycle pulse when a frame edge arrives while busy
//   ovr_cnt     saturating overrun count
// -----------------------------------------------------------------------------
interface pulse_sched_if
    import pulse_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int GAP_W = GAP_W_DEF
);

    localparam int IDX_W = $clog2(NCH);

    logic              fd;
    logic [NCH-1:0]    ch_en;
    logic [GAP_W-1:0]  gap;
    logic [NCH-1:0]    stb;
    logic [IDX_W-1:0]  ch_idx;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic [OVR_W-1:0]  ovr_cnt;

    modport master (
        input  fd, ch_en, gap,
        output stb, ch_idx, busy, frame_done, overrun, ovr_cnt
    );

    modport slave (
        output fd, ch_en, gap,
        input  stb, ch_idx, busy, frame_done, overrun, ovr_cnt
    );

endinterface

// File: rtl/pulse_sched_fd_sync_edge.sv
// -----------------------------------------------------------------------------
// fd_sync_edge
// Two-flop synchronizer for the asynchronous frame strobe plus a delay flop
// for rising-edge detection.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   fd    raw frame strobe level
//   rise  one-cycle pulse on a synchronized 0->1 transition
// All three flops reset to 1, so an fd held high through reset release never
// looks like an edge; the first frame needs fd to drop and rise again.
// -----------------------------------------------------------------------------
module fd_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic fd,
    output logic rise
);

    logic fd_m;
    logic fd_s;
    logic fd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fd_m <= 1'b1;
            fd_s <= 1'b1;
            fd_d <= 1'b1;
        end else begin
            fd_m <= fd;
            fd_s <= fd_m;
            fd_d <= fd_s;
        end
    end

    assign rise = fd_s & ~fd_d;

endmodule

// File: rtl/pulse_sched.sv
// -----------------------------------------------------------------------------
// pulse_sched
// Frame-level pulse scheduler. On each synchronized rising edge of fd it
// walks channels 0..NCH-1 and issues one single-cycle strobe per enabled
// channel, leaving `gap` idle cycles after each strobe. Enables and gap are
// captured once per frame. A frame edge that arrives mid-scan is dropped and
// reported through overrun / ovr_cnt.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   pulse_sched_if.master (fd, ch_en, gap in; stb, ch_idx, busy,
//         frame_done, overrun, ovr_cnt out)
// Timing (k = first clk edge sampling fd=1):
//   rise visible in cycle k+1, SCAN entered at k+2, stb[0] in cycle k+3.
//   busy covers the strobe window; frame_done follows one cycle after it.
// -----------------------------------------------------------------------------
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    pulse_sched_if.master bus
);

    localparam int                IDX_W    = $clog2(NCH);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NCH - 1);

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == {OVR_W{1'b1}}) ? v : v + OVR_W'(1);
    endfunction

    logic              rise;

    state_t            state;
    state_t            state_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic [GAP_W-1:0]  cnt;
    logic [GAP_W-1:0]  cnt_n;

    logic [NCH-1:0]    en_snap;
    logic [GAP_W-1:0]  gap_snap;

    logic [NCH-1:0]    stb_n;
    logic              fire;
    logic              adv;
    logic              fin;
    logic              ovr_hit;

    logic [NCH-1:0]    stb_r;
    logic              busy_r;
    logic              done_p0;
    logic              frame_done_r;
    logic              overrun_r;
    logic [OVR_W-1:0]  ovr_cnt_r;

    fd_sync_edge u_fd_sync (
        .clk  (clk),
        .rst  (rst),
        .fd   (bus.fd),
        .rise (rise)
    );

    // An edge is only accepted from IDLE; anywhere else it is an overrun.
    assign ovr_hit = rise && (state != S_IDLE);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        stb_n   = '0;
        fire    = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;

        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n = S_SCAN;
                    idx_n   = '0;
                end
            end
            S_SCAN: begin
                fire       = en_snap[idx];
                stb_n[idx] = fire;
                if (fire && (gap_snap != '0)) begin
                    cnt_n   = gap_snap;
                    state_n = S_GAP;
                end else begin
                    adv = 1'b1;
                end
            end
            S_GAP: begin
                // The last gap cycle (counter at 1) doubles as the advance
                // cycle, so an enabled channel takes exactly 1+gap cycles.
                if (cnt <= GAP_W'(1)) begin
                    cnt_n = '0;
                    adv   = 1'b1;
                end else begin
                    cnt_n = cnt - GAP_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase

        if (adv) begin
            if (idx == IDX_LAST) begin
                state_n = S_IDLE;
                idx_n   = '0;
                fin     = 1'b1;
            end else begin
                state_n = S_SCAN;
                idx_n   = idx + IDX_W'(1);
            end
        end
    end

    // Frame configuration snapshot: data only, meaningless outside a scan.
    always_ff @(posedge clk) begin
        if ((state == S_IDLE) && rise) begin
            en_snap  <= bus.ch_en;
            gap_snap <= bus.gap;
        end
    end

    // Control and output registers; done_p0 delays the finish flag so that
    // frame_done lands one cycle after the final strobe slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            cnt          <= '0;
            stb_r        <= '0;
            busy_r       <= 1'b0;
            done_p0      <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            ovr_cnt_r    <= '0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            cnt          <= cnt_n;
            stb_r        <= stb_n;
            busy_r       <= (state != S_IDLE);
            done_p0      <= fin;
            frame_done_r <= done_p0;
            overrun_r    <= ovr_hit;
            if (ovr_hit) begin
                ovr_cnt_r <= sat_inc(ovr_cnt_r);
            end
        end
    end

    assign bus.stb        = stb_r;
    assign bus.ch_idx     = idx;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
    assign bus.overrun    = overrun_r;
    assign bus.ovr_cnt    = ovr_cnt_r;

endmodule

// File: tb/tb_pulse_sched.sv
// -----------------------------------------------------------------------------
// tb_pulse_sched
// Directed stimulus for pulse_sched. Each frame launch pushes the expected
// strobe cycles/channels, frame_done cycle and overrun cycles/counts into
// queues; independent monitors pop and compare whenever the DUT raises
// stb, frame_done or overrun.
// Cycle numbering: cyc = number of rising clk edges so far; fd is driven 1
// time unit after an edge, so the next edge (cyc+1) is edge k.
// -----------------------------------------------------------------------------
module tb_pulse_sched;
    import pulse_sched_pkg::*;

    localparam int NCH   = 32;
    localparam int GAP_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int n_cmp = 0;
    int n_bad = 0;

    int q_stb_cyc[$];
    int q_stb_ch[$];
    int q_done_cyc[$];
    int q_ovr_cyc[$];
    int q_ovr_val[$];

    pulse_sched_if #(.NCH(NCH), .GAP_W(GAP_W)) bus ();

    pulse_sched #(.NCH(NCH), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------ helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected schedule of one frame whose fd edge is sampled at edge k.
    task automatic push_frame(input int k, input logic [NCH-1:0] en, input int g);
        int t;
        t = k + 3;
        for (int i = 0; i < NCH; i++) begin
            if (en[i]) begin
                q_stb_cyc.push_back(t);
                q_stb_ch.push_back(i);
                t = t + g + 1;
            end else begin
                t = t + 1;
            end
        end
        q_done_cyc.push_back(t);
    endtask

    // ----------------------------------------------------------------- monitors
    logic [NCH-1:0] mon_exp_stb;
    int             mon_c;
    int             mon_v;

    always @(negedge clk) begin
        if (bus.stb != '0) begin
            n_cmp++;
            if (q_stb_cyc.size() == 0) begin
                n_bad++;
                $display("FAIL stb_unexpected: got stb=%h at cyc %0d, expected none", bus.stb, cyc);
            end else begin
                mon_c       = q_stb_cyc.pop_front();
                mon_v       = q_stb_ch.pop_front();
                mon_exp_stb = '0;
                mon_exp_stb[mon_v] = 1'b1;
                if ((cyc != mon_c) || (bus.stb != mon_exp_stb) || (bus.busy !== 1'b1)) begin
                    n_bad++;
                    $display("FAIL stb: got stb=%h busy=%b at cyc %0d, expected stb=%h busy=1 at cyc %0d",
                             bus.stb, bus.busy, cyc, mon_exp_stb, mon_c);
                end
            end
        end
        if (bus.frame_done) begin
            n_cmp++;
            if (q_done_cyc.size() == 0) begin
                n_bad++;
                $display("FAIL done_unexpected: got frame_done at cyc %0d, expected none", cyc);
            end else begin
                mon_c = q_done_cyc.pop_front();
                if ((cyc != mon_c) || (bus.busy !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL frame_done: got cyc %0d busy=%b, expected cyc %0d busy=0",
                             cyc, bus.busy, mon_c);
                end
            end
        end
        if (bus.overrun) begin
            n_cmp++;
            if (q_ovr_cyc.size() == 0) begin
                n_bad++;
                $display("FAIL ovr_unexpected: got overrun at cyc %0d cnt=%0d, expected none", cyc, bus.ovr_cnt);
            end else begin
                mon_c = q_ovr_cyc.pop_front();
                mon_v = q_ovr_val.pop_front();
                if ((cyc != mon_c) || (int'(bus.ovr_cnt) != mon_v)) begin
                    n_bad++;
                    $display("FAIL overrun: got cyc %0d cnt=%0d, expected cyc %0d cnt=%0d",
                             cyc, bus.ovr_cnt, mon_c, mon_v);
                end
            end
        end
    end

    // ----------------------------------------------------------------- stimulus
    initial begin
        int k;
        int k2;
        int exp_cnt;

        bus.fd    = 1'b0;
        bus.ch_en = '1;
        bus.gap   = '0;
        #5 rst = 1'b1;
        step(3);

        chk("rst_stb",        bus.stb,        0);
        chk("rst_busy",       bus.busy,       0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overrun",    bus.overrun,    0);
        chk("rst_ovr_cnt",    bus.ovr_cnt,    0);
        chk("rst_ch_idx",     bus.ch_idx,     0);
        rst = 1'b0;
        step(5);

        // All enabled, gap 0; second edge lands on the frame_done cycle.
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, '1, 0);
        step(10);
        bus.fd = 1'b0;
        step(k + 33 - cyc);
        bus.fd = 1'b1;
        k2 = cyc + 1;
        push_frame(k2, '1, 0);
        step(10);
        bus.fd = 1'b0;
        step(40);
        chk("t1_ovr_cnt", bus.ovr_cnt, 0);
        chk("t1_idle_idx", bus.ch_idx, 0);

        // Channels 0 and 2, gap 3.
        bus.ch_en = 32'h0000_0005;
        bus.gap   = 8'd3;
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, 32'h0000_0005, 3);
        step(10);
        bus.fd = 1'b0;
        step(45);

        // Enables cleared mid-frame: this frame unaffected, next frame empty.
        bus.ch_en = '1;
        bus.gap   = '0;
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, '1, 0);
        step(10);
        bus.ch_en = '0;
        bus.fd    = 1'b0;
        step(35);
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, '0, 0);
        step(10);
        bus.fd = 1'b0;
        step(35);

        // gap 255, fd at 5 kHz: second edge overruns and is dropped.
        bus.ch_en = '1;
        bus.gap   = 8'd255;
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, '1, 255);
        step(2500);
        bus.fd = 1'b0;
        step(2499);
        bus.fd = 1'b1;
        k2 = cyc + 1;
        q_ovr_cyc.push_back(k2 + 2);
        q_ovr_val.push_back(1);
        step(10);
        bus.fd = 1'b0;
        step(k + 8200 - cyc);
        chk("t3_ovr_cnt", bus.ovr_cnt, 1);

        // 300 forced overruns during one long frame: counter saturates.
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, '1, 255);
        step(10);
        bus.fd = 1'b0;
        step(4);
        exp_cnt = 1;
        for (int j = 0; j < 300; j++) begin
            bus.fd = 1'b1;
            k2 = cyc + 1;
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            q_ovr_cyc.push_back(k2 + 2);
            q_ovr_val.push_back(exp_cnt);
            step(2);
            bus.fd = 1'b0;
            step(2);
        end
        step(k + 8200 - cyc);
        chk("t6_ovr_cnt_sat", bus.ovr_cnt, 255);

        // Reset mid-scan with fd held high: no phantom edge afterwards.
        bus.gap = '0;
        k = cyc + 1;
        bus.fd = 1'b1;
        for (int i = 0; i < 11; i++) begin
            q_stb_cyc.push_back(k + 3 + i);
            q_stb_ch.push_back(i);
        end
        step(k + 14 - cyc);
        rst = 1'b1;
        #1;
        chk("mid_rst_stb",     bus.stb,     0);
        chk("mid_rst_busy",    bus.busy,    0);
        chk("mid_rst_ovr_cnt", bus.ovr_cnt, 0);
        chk("mid_rst_ch_idx",  bus.ch_idx,  0);
        step(k + 19 - cyc);
        rst = 1'b0;
        step(20);
        chk("post_rst_busy", bus.busy, 0);
        bus.fd = 1'b0;
        step(5);
        k = cyc + 1;
        bus.fd = 1'b1;
        push_frame(k, '1, 0);
        step(10);
        bus.fd = 1'b0;
        step(40);

        chk("left_stb",  q_stb_cyc.size(),  0);
        chk("left_done", q_done_cyc.size(), 0);
        chk("left_ovr",  q_ovr_cyc.size(),  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
